fwd_sel_ctrl: RTL and testbench



---
 rtl/fwd_sel_ctrl_if.sv | 41 ++++
 rtl/fwd_sel_ctrl.sv | 136 +++++++++++++
 tb/tb_fwd_sel_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fwd_sel_ctrl_if.sv
// rtl/fwd_sel_ctrl_if.sv - ID-stage request and forwarding/stall response bundle
// stall_cnt exists only when FWD_STALL_CNT_EN is defined.
interface fwd_sel_ctrl_if #(
  parameter int RW = 5
);
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_b_imm;
  logic          flush;
  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic          stall;
  logic          ex_valid;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_b_imm, flush,
`ifdef FWD_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  sel_a, sel_b, stall, ex_valid
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_b_imm, flush,
`ifdef FWD_STALL_CNT_EN
    output stall_cnt,
`endif
    output sel_a, sel_b, stall, ex_valid
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - operand-forwarding select and load-use stall controller
// Optional saturating stall counter enabled by FWD_STALL_CNT_EN.
module fwd_sel_ctrl #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  fwd_sel_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e        state_q, state_d;

  logic          ex_valid_q;
  logic          ex_regwrite_q;
  logic          ex_memread_q;
  logic [RW-1:0] ex_rd_q;
  logic          mem_valid_q;
  logic          mem_regwrite_q;
  logic [RW-1:0] mem_rd_q;
  logic [1:0]    sel_a_q, sel_a_d;
  logic [1:0]    sel_b_q, sel_b_d;

  logic          rs1_ex_hit, rs2_ex_hit;
  logic          rs1_mem_hit, rs2_mem_hit;
  logic          stall_w;
  logic          bubble_w;

  // A zero source never matches, which also keeps x0 writers from forwarding.
  always_comb begin
    rs1_ex_hit  = bus.id_use_rs1 && (bus.id_rs1 != '0) && ex_valid_q &&
                  ex_regwrite_q && (ex_rd_q == bus.id_rs1);
    rs2_ex_hit  = bus.id_use_rs2 && (bus.id_rs2 != '0) && ex_valid_q &&
                  ex_regwrite_q && (ex_rd_q == bus.id_rs2);
    rs1_mem_hit = bus.id_use_rs1 && (bus.id_rs1 != '0) && mem_valid_q &&
                  mem_regwrite_q && (mem_rd_q == bus.id_rs1);
    rs2_mem_hit = bus.id_use_rs2 && (bus.id_rs2 != '0) && mem_valid_q &&
                  mem_regwrite_q && (mem_rd_q == bus.id_rs2);
  end

  always_comb begin
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (bus.id_valid) begin
      if (rs1_ex_hit)       sel_a_d = 2'b01;
      else if (rs1_mem_hit) sel_a_d = 2'b10;

      if (bus.id_b_imm)     sel_b_d = 2'b11;
      else if (rs2_ex_hit)  sel_b_d = 2'b01;
      else if (rs2_mem_hit) sel_b_d = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (stall_w) state_d = ST_STALL;
      ST_STALL: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (bus.flush) state_d = ST_RUN;
  end

  // Only a load still in EX can stall; once it reaches MEM it forwards instead.
  always_comb begin
    stall_w  = bus.id_valid && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
               (rs1_ex_hit || rs2_ex_hit) && !bus.flush;
    bubble_w = stall_w || bus.flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_rd_q        <= '0;
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      sel_a_q        <= 2'b00;
      sel_b_q        <= 2'b00;
    end else begin
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      if (bubble_w) begin
        ex_valid_q    <= 1'b0;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
        ex_rd_q       <= '0;
        sel_a_q       <= 2'b00;
        sel_b_q       <= 2'b00;
      end else begin
        ex_valid_q    <= bus.id_valid;
        ex_regwrite_q <= bus.id_valid && bus.id_regwrite;
        ex_memread_q  <= bus.id_valid && bus.id_memread;
        ex_rd_q       <= bus.id_valid ? bus.id_rd : '0;
        sel_a_q       <= sel_a_d;
        sel_b_q       <= sel_b_d;
      end
    end
  end

  assign bus.sel_a    = sel_a_q;
  assign bus.sel_b    = sel_b_q;
  assign bus.stall    = stall_w;
  assign bus.ex_valid = ex_valid_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cnt_q <= '0;
    else if (stall_w && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // The stalled load has moved to MEM, so the hazard cannot re-fire here.
  a_no_stall_in_stall: assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == ST_STALL) |-> !stall_w
  );
`endif

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb/tb_fwd_sel_ctrl.sv - self-checking bench for fwd_sel_ctrl against an in-flight queue model
module tb_fwd_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_sel_ctrl_if #(.RW(5)) bus ();
  fwd_sel_ctrl #(.RW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } slot_t;

  // pipe[0] is the instruction in EX, pipe[1] the one in MEM.
  slot_t       pipe[$];
  int unsigned cnt_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input slot_t p, input logic u, input logic [4:0] s);
    return u && (s != 5'd0) && p.v && p.rw && (p.rd == s);
  endfunction

  task automatic model_reset();
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    cnt_m = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic imm, input logic fl);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_use_rs1  = u1;
    bus.id_use_rs2  = u2;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_b_imm    = imm;
    bus.flush       = fl;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic imm, input logic fl,
                       output logic st);
    logic       es;
    logic [1:0] ea, eb;
    slot_t      nx;
    @(negedge clk);
    drive(v, rs1, rs2, u1, u2, rd, rw, mr, imm, fl);
    #1;
    es = v && pipe[0].v && pipe[0].mr && (pipe[0].rd != 5'd0) &&
         (hit(pipe[0], u1, rs1) || hit(pipe[0], u2, rs2)) && !fl;
    st = bus.stall;
    check("stall", {31'd0, bus.stall}, {31'd0, es});
    ea = 2'b00;
    eb = 2'b00;
    nx = '0;
    if (v && !es && !fl) begin
      ea = hit(pipe[0], u1, rs1) ? 2'b01 : hit(pipe[1], u1, rs1) ? 2'b10 : 2'b00;
      eb = imm ? 2'b11 : hit(pipe[0], u2, rs2) ? 2'b01 : hit(pipe[1], u2, rs2) ? 2'b10 : 2'b00;
      nx = '{v: 1'b1, rd: rd, rw: rw, mr: mr};
    end
    @(posedge clk);
    #1;
    pipe.push_front(nx);
    void'(pipe.pop_back());
    if (es && cnt_m != 32'hFFFF_FFFF) cnt_m++;
    check("sel_a", {30'd0, bus.sel_a}, {30'd0, ea});
    check("sel_b", {30'd0, bus.sel_b}, {30'd0, eb});
    check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, nx.v});
`ifdef FWD_STALL_CNT_EN
    check("stall_cnt", bus.stall_cnt, cnt_m);
`endif
  endtask

  initial begin
    logic       st;
    logic       hv, hu1, hu2, hrw, hmr, himm, hfl;
    logic [4:0] hrs1, hrs2, hrd;

    model_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      #1;
      check("rst_sel_a", {30'd0, bus.sel_a}, 32'd0);
      check("rst_sel_b", {30'd0, bus.sel_b}, 32'd0);
      check("rst_stall", {31'd0, bus.stall}, 32'd0);
      check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    issue(1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);

    // EX forward
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("ex_fwd_sel_a", {30'd0, bus.sel_a}, 32'd1);
    check("ex_fwd_sel_b", {30'd0, bus.sel_b}, 32'd0);

    // EX beats MEM, then MEM alone
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("prio_sel_b", {30'd0, bus.sel_b}, 32'd1);
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("mem_sel_b", {30'd0, bus.sel_b}, 32'd2);

    // load-use
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, st);
    issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("lu_stall", {31'd0, st}, 32'd1);
    check("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("lu_stall_once", {31'd0, st}, 32'd0);
    check("lu_sel_a", {30'd0, bus.sel_a}, 32'd2);
`ifdef FWD_STALL_CNT_EN
    check("lu_cnt", bus.stall_cnt, 32'd1);
`endif

    // x0 and immediate
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("x0_sel_a", {30'd0, bus.sel_a}, 32'd0);
    check("x0_sel_b", {30'd0, bus.sel_b}, 32'd0);
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, st);
    issue(1'b1, 5'd3, 5'd12, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, st);
    check("imm_sel_b", {30'd0, bus.sel_b}, 32'd3);

    // flush during load-use
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, st);
    issue(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1, st);
    check("fl_stall", {31'd0, st}, 32'd0);
    check("fl_bubble", {31'd0, bus.ex_valid}, 32'd0);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
`ifdef FWD_STALL_CNT_EN
    check("fl_cnt", bus.stall_cnt, 32'd1);
`endif

    // reset asserted while a stall is pending
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, st);
    @(negedge clk);
    drive(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("mid_stall_pre", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    check("mid_rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("mid_rst_sel_a", {30'd0, bus.sel_a}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    check("mid_rst_cnt", bus.stall_cnt, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("post_rst_stall", {31'd0, st}, 32'd0);

    // randomized traffic; a stalled instruction is re-presented unchanged
    st = 1'b0;
    {hv, hu1, hu2, hrw, hmr, himm, hfl} = '0;
    {hrs1, hrs2, hrd} = '0;
    for (int i = 0; i < 400; i++) begin
      if (!st) begin
        hv   = ($urandom_range(0, 9) < 8);
        hrs1 = 5'($urandom_range(0, 7));
        hrs2 = 5'($urandom_range(0, 7));
        hu1  = 1'($urandom);
        hu2  = 1'($urandom);
        hrd  = 5'($urandom_range(0, 7));
        hrw  = ($urandom_range(0, 3) != 0);
        hmr  = ($urandom_range(0, 2) == 0);
        himm = ($urandom_range(0, 3) == 0);
      end
      hfl = ($urandom_range(0, 9) == 0);
      issue(hv, hrs1, hrs2, hu1, hu2, hrd, hrw, hmr, himm, hfl, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
